// File: rtl/matrix_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_pkg: shared defaults, channel indices and PWM helper for the   |
// | LED matrix scan driver.                    Revision: 1.0              |
// +----------------------------------------------------------------------+
package matrix_pkg;

  localparam int MATRIX_ROWS     = 8;
  localparam int MATRIX_COLS     = 8;
  localparam int MATRIX_CHANNELS = 2;
  localparam int MATRIX_BRIGHT_W = 3;

  localparam int CH_RED   = 0;
  localparam int CH_GREEN = 1;

  // Tick 0 of every dwell is blanked so the previous row never ghosts.
  function automatic logic pwm_on(input int unsigned dwell, input int unsigned level);
    return (dwell != 0) && (dwell <= level);
  endfunction

endpackage
`default_nettype wire

// File: rtl/row_scanner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | row_scanner: tick-gated row/dwell counters with frame-wrap flags.     |
// |                                            Revision: 1.0              |
// +----------------------------------------------------------------------+
module row_scanner #(
  parameter  int ROWS    = 8,
  parameter  int DWELL   = 8,
  localparam int ROW_W   = $clog2(ROWS),
  localparam int DWELL_W = $clog2(DWELL)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  output logic [ROW_W-1:0]   row_next,
  output logic [DWELL_W-1:0] dwell_next,
  output logic               boundary,
  output logic               wrap
);

  logic [ROW_W-1:0]   r_row;
  logic [DWELL_W-1:0] r_dwell;
  logic               w_last_row;
  logic               w_last_dwell;

  assign w_last_row   = (r_row == ROW_W'(ROWS - 1));
  assign w_last_dwell = (r_dwell == DWELL_W'(DWELL - 1));
  assign boundary     = tick & w_last_row & w_last_dwell;

  // Next-state values are exported so the top can register its pins on the
  // same edge that moves the counters, giving zero latency to the pins.
  always_comb begin
    row_next   = r_row;
    dwell_next = r_dwell;
    if (tick) begin
      if (w_last_dwell) begin
        dwell_next = '0;
        row_next   = w_last_row ? '0 : r_row + 1'b1;
      end else begin
        dwell_next = r_dwell + 1'b1;
      end
    end
  end

  assign wrap = tick && (row_next == '0) && (dwell_next == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_row   <= '0;
      r_dwell <= '0;
    end else begin
      r_row   <= row_next;
      r_dwell <= dwell_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/matrix_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | matrix_scan_driver: double-buffered, PWM-dimmed row-scan LED driver.  |
// |                                            Revision: 1.0              |
// +----------------------------------------------------------------------+
module matrix_scan_driver
  import matrix_pkg::*;
#(
  parameter int ROWS     = MATRIX_ROWS,
  parameter int COLS     = MATRIX_COLS,
  parameter int CHANNELS = MATRIX_CHANNELS,
  parameter int BRIGHT_W = MATRIX_BRIGHT_W
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         tick,
  input  logic [CHANNELS*ROWS*COLS-1:0] frame,
  input  logic                         frame_valid,
  output logic                         frame_ack,
  input  logic [BRIGHT_W-1:0]          brightness,
  output logic [CHANNELS*COLS-1:0]     col_drive,
  output logic [ROWS-1:0]              row_sink,
  output logic                         frame_start
);

  localparam int DWELL = 2 ** BRIGHT_W;
  localparam int ROW_W = $clog2(ROWS);
  localparam int PLANE = ROWS * COLS;

  logic [ROW_W-1:0]               w_row_next;
  logic [BRIGHT_W-1:0]            w_dwell_next;
  logic                           w_boundary;
  logic                           w_wrap;
  logic                           w_capture;
  logic                           w_on;
  logic [CHANNELS*ROWS*COLS-1:0]  r_disp;
  logic [CHANNELS*ROWS*COLS-1:0]  w_disp_next;
  logic [CHANNELS*COLS-1:0]       w_cols;

  row_scanner #(
    .ROWS  (ROWS),
    .DWELL (DWELL)
  ) u_row_scanner (
    .clock      (clock),
    .reset      (reset),
    .tick       (tick),
    .row_next   (w_row_next),
    .dwell_next (w_dwell_next),
    .boundary   (w_boundary),
    .wrap       (w_wrap)
  );

  // The swap happens only on the last tick of the frame, so rows never tear.
  assign w_capture   = w_boundary & frame_valid;
  assign w_disp_next = w_capture ? frame : r_disp;
  assign w_on        = pwm_on(32'(w_dwell_next), 32'(brightness));

  for (genvar gc = 0; gc < CHANNELS; gc++) begin : g_chan
    for (genvar gk = 0; gk < COLS; gk++) begin : g_col
      logic [ROWS-1:0] w_column;
      for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
        assign w_column[gr] = w_disp_next[gc*PLANE + gr*COLS + gk];
      end
      assign w_cols[gc*COLS + gk] = w_column[w_row_next] & w_on;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_disp      <= '0;
      col_drive   <= '0;
      row_sink    <= '1;
      frame_ack   <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_ack   <= w_capture;
      frame_start <= w_wrap;
      if (tick) begin
        r_disp    <= w_disp_next;
        col_drive <= w_cols;
        row_sink  <= ~(ROWS'(1) << w_row_next);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_driver.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_matrix_scan_driver: randomized bench with a tick-count model.      |
// |                                            Revision: 1.0              |
// +----------------------------------------------------------------------+
module tb_matrix_scan_driver;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int CH   = 2;
  localparam int BW   = 3;
  localparam int DW   = 8;
  localparam int FP   = ROWS * DW;

  logic                   clock = 1'b0;
  logic                   reset;
  logic                   tick;
  logic [CH*ROWS*COLS-1:0] frame;
  logic                   frame_valid;
  logic                   frame_ack;
  logic [BW-1:0]          brightness;
  logic [CH*COLS-1:0]     col_drive;
  logic [ROWS-1:0]        row_sink;
  logic                   frame_start;

  int vectors     = 0;
  int miscompares = 0;
  bit checking    = 0;

  matrix_scan_driver #(
    .ROWS(ROWS), .COLS(COLS), .CHANNELS(CH), .BRIGHT_W(BW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .brightness  (brightness),
    .col_drive   (col_drive),
    .row_sink    (row_sink),
    .frame_start (frame_start)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: everything follows from the number of ticks since reset.
  int unsigned             m_t;
  logic [CH*ROWS*COLS-1:0] m_disp;
  logic [BW-1:0]           m_br;
  bit                      m_ticked;
  bit                      e_ack;
  bit                      e_start;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_t = 0; m_disp = '0; m_br = '0; m_ticked = 0; e_ack = 0; e_start = 0;
    end else begin
      e_start = tick && (m_t % FP == FP - 1);
      e_ack   = e_start && frame_valid;
      if (tick) begin
        if (e_ack) m_disp = frame;
        m_t++;
        m_ticked = 1;
        m_br = brightness;
      end
    end
  end

  function automatic logic [ROWS-1:0] model_rs();
    int row = (m_t / DW) % ROWS;
    logic [ROWS-1:0] v = '1;
    if (m_ticked) v[row] = 1'b0;
    return v;
  endfunction

  function automatic logic [CH*COLS-1:0] model_cols();
    int row = (m_t / DW) % ROWS;
    int d = m_t % DW;
    logic on = m_ticked && (d != 0) && (d <= int'(m_br));
    logic [CH*COLS-1:0] v = '0;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < COLS; k++)
        v[c*COLS + k] = m_disp[c*ROWS*COLS + row*COLS + k] & on;
    return v;
  endfunction

  always @(negedge clock) begin
    if (checking && !reset) begin
      check("row_sink", 64'(row_sink), 64'(model_rs()));
      check("col_drive", 64'(col_drive), 64'(model_cols()));
      check("frame_ack", 64'(frame_ack), 64'(e_ack));
      check("frame_start", 64'(frame_start), 64'(e_start));
    end
  end

  task automatic wait_ack(input string nm);
    bit seen = 0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clock);
      if (frame_ack) seen = 1;
    end
    check(nm, 64'(seen), 64'd1);
    frame_valid = 1'b0;
  endtask

  logic [CH*ROWS*COLS-1:0] diag;
  logic [ROWS-1:0]         saved_rs;
  logic [CH*COLS-1:0]      saved_cd;
  int n;
  int acks;

  initial begin
    reset = 1'b1; tick = 1'b0; frame = '0; frame_valid = 1'b0; brightness = 3'd7;
    repeat (3) @(negedge clock);
    check("rst_row_sink", 64'(row_sink), 64'hFF);
    check("rst_col_drive", 64'(col_drive), 64'h0);
    reset = 1'b0; tick = 1'b1; checking = 1;
    @(negedge clock);
    check("first_tick_row_sink", 64'(row_sink), 64'hFE);

    // Scan with a full-on frame.
    frame = '1; frame_valid = 1'b1;
    wait_ack("ack_full_frame");
    check("swap_row0", 64'(row_sink), 64'hFE);
    check("swap_blank", 64'(col_drive), 64'h0);
    @(negedge clock);
    check("swap_d1_cols", 64'(col_drive), 64'hFFFF);

    n = 0;
    while (!frame_start && n < 200) begin @(negedge clock); n++; end
    n = 0;
    do begin @(negedge clock); n++; end while (!frame_start && n < 200);
    check("start_period", 64'(n), 64'd64);

    // Tear-free swap to a red diagonal.
    repeat (20) @(negedge clock);
    diag = '0;
    for (int k = 0; k < ROWS; k++) diag[k*COLS + k] = 1'b1;
    frame = diag; frame_valid = 1'b1;
    wait_ack("ack_diag");
    repeat (25) @(negedge clock);
    check("diag_row3_sink", 64'(row_sink), 64'hF7);
    check("diag_row3_cols", 64'(col_drive), 64'h0008);

    // Brightness levels over a full frame each.
    brightness = 3'd0; n = 0;
    repeat (FP) begin @(negedge clock); if (col_drive != 0) n++; end
    check("bright0_on_ticks", 64'(n), 64'd0);
    brightness = 3'd3; n = 0;
    repeat (FP) begin @(negedge clock); if (col_drive != 0) n++; end
    check("bright3_on_ticks", 64'(n), 64'd24);

    // Tick gating mid-row.
    repeat (3) @(negedge clock);
    saved_rs = row_sink; saved_cd = col_drive;
    tick = 1'b0; brightness = 3'd0;
    repeat (20) @(negedge clock);
    check("gate_row_sink", 64'(row_sink), 64'(saved_rs));
    check("gate_col_drive", 64'(col_drive), 64'(saved_cd));
    tick = 1'b1;

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      if (frame_ack) frame_valid = 1'b0;
      else if (!frame_valid && $urandom_range(0, 3) == 0) begin
        frame = {$urandom, $urandom, $urandom, $urandom};
        frame_valid = 1'b1;
      end
      tick = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) brightness = 3'($urandom);
    end

    // Reset mid-frame with a request pending.
    @(negedge clock);
    frame_valid = 1'b0; tick = 1'b1; brightness = 3'd7;
    @(negedge clock);
    frame = {$urandom, $urandom, $urandom, $urandom}; frame_valid = 1'b1;
    repeat (10) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("midrst_row_sink", 64'(row_sink), 64'hFF);
    check("midrst_col_drive", 64'(col_drive), 64'h0);
    check("midrst_ack", 64'(frame_ack), 64'h0);
    @(negedge clock);
    reset = 1'b0;
    acks = 0;
    repeat (100) begin
      @(negedge clock);
      if (frame_ack) begin acks++; frame_valid = 1'b0; end
    end
    check("post_reset_acks", 64'(acks), 64'd1);

    checking = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
